// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole blocks: game state encoding and LFSR constants.
package mole_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHOW,
        S_RELEASE,
        S_OVER
    } mole_state_t;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11: feedback from bits 0, 2, 3 and 5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/mole_pattern_pick.sv
// Free-running LFSR plus a picker that turns its state into a pattern with exactly num_lit bits set.
module mole_pattern_pick
    import mole_pkg::*;
#(
    parameter int unsigned N_MOLES = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [15:0]        seed,
    input  logic [4:0]         num_lit,
    output logic [N_MOLES-1:0] pattern
);

    logic [LFSR_W-1:0]  lfsr;
    logic [N_MOLES-1:0] pick;
    logic [4:0]         cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            lfsr <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
        end else begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
        end
    end

    // LFSR one-bits win from the lowest index up; any shortfall is filled from the lowest clear bits.
    always_comb begin
        pick = '0;
        cnt  = '0;
        for (int i = 0; i < int'(N_MOLES); i++) begin
            if (lfsr[i] && (cnt < num_lit)) begin
                pick[i] = 1'b1;
                cnt     = cnt + 5'd1;
            end
        end
        for (int i = 0; i < int'(N_MOLES); i++) begin
            if (!pick[i] && (cnt < num_lit)) begin
                pick[i] = 1'b1;
                cnt     = cnt + 5'd1;
            end
        end
    end

    assign pattern = pick;

endmodule

// File: rtl/mole_round_engine.sv
// Whack-a-mole game core: rounds, press detection with lockout, lives, saturating score and level.
module mole_round_engine
    import mole_pkg::*;
#(
    parameter int unsigned N_MOLES         = 7,
    parameter int unsigned SCORE_W         = 8,
    parameter int unsigned TIMER_W         = 16,
    parameter int unsigned GAME_TICKS      = 60000,
    parameter int unsigned ROUND_TICKS     = 5000,
    parameter int unsigned ROUND_STEP      = 1000,
    parameter int unsigned MIN_ROUND_TICKS = 1000,
    parameter int unsigned LEVEL_STEP      = 5,
    parameter int unsigned MAX_LEVEL       = 3,
    parameter int unsigned LIVES           = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               start,
    input  logic [N_MOLES-1:0] btn,
    input  logic [15:0]        seed,
    output logic [N_MOLES-1:0] mole_out,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         level,
    output logic [2:0]         lives,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    mole_state_t        state, state_next;
    logic [TIMER_W-1:0] game_timer, game_timer_next;
    logic [TIMER_W-1:0] round_timer, round_timer_next;
    logic [N_MOLES-1:0] pattern_q, pattern_next;
    logic [N_MOLES-1:0] hit_mask, hit_mask_next;
    logic [N_MOLES-1:0] lockout, lockout_next;
    logic [N_MOLES-1:0] btn_q, press, pick;
    logic [SCORE_W-1:0] score_next;
    logic [2:0]         level_next, lives_next, lives_dec;
    logic               hit_next, miss_next, load_seed, in_game;
    logic [4:0]         num_lit;

    function automatic logic [2:0] level_of(input logic [SCORE_W-1:0] s);
        int unsigned q;
        q = 32'(s) / LEVEL_STEP;
        if (q > MAX_LEVEL) q = MAX_LEVEL;
        return 3'(q);
    endfunction

    // Round length shrinks per level but never below the floor, and never wraps.
    function automatic logic [TIMER_W-1:0] round_len(input logic [2:0] lvl);
        int unsigned cut, len;
        cut = 32'(lvl) * ROUND_STEP;
        len = (cut >= ROUND_TICKS) ? MIN_ROUND_TICKS : (ROUND_TICKS - cut);
        if (len < MIN_ROUND_TICKS) len = MIN_ROUND_TICKS;
        return TIMER_W'(len);
    endfunction

    assign num_lit   = ((32'(level) + 1) > N_MOLES) ? 5'(N_MOLES) : (5'(level) + 5'd1);
    assign press     = btn & ~btn_q & ~lockout;
    assign lives_dec = (lives == 3'd0) ? 3'd0 : (lives - 3'd1);

    mole_pattern_pick #(
        .N_MOLES (N_MOLES)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_seed),
        .seed    (seed),
        .num_lit (num_lit),
        .pattern (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            game_timer  <= '0;
            round_timer <= '0;
            pattern_q   <= '0;
            hit_mask    <= '0;
            lockout     <= '0;
            btn_q       <= '0;
            score       <= '0;
            level       <= '0;
            lives       <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            state       <= state_next;
            game_timer  <= game_timer_next;
            round_timer <= round_timer_next;
            pattern_q   <= pattern_next;
            hit_mask    <= hit_mask_next;
            lockout     <= lockout_next;
            btn_q       <= btn;
            score       <= score_next;
            level       <= level_next;
            lives       <= lives_next;
            hit_pulse   <= hit_next;
            miss_pulse  <= miss_next;
        end
    end

    always_comb begin
        state_next       = state;
        game_timer_next  = game_timer;
        round_timer_next = round_timer;
        pattern_next     = pattern_q;
        hit_mask_next    = hit_mask;
        lockout_next     = lockout;
        score_next       = score;
        lives_next       = lives;
        hit_next         = 1'b0;
        miss_next        = 1'b0;
        load_seed        = 1'b0;
        in_game          = (state == S_ARM) || (state == S_SHOW) || (state == S_RELEASE);

        if (in_game && tick && (game_timer != '0)) begin
            game_timer_next = game_timer - TIMER_W'(1);
        end

        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    load_seed       = 1'b1;
                    game_timer_next = TIMER_W'(GAME_TICKS);
                    lives_next      = 3'(LIVES);
                    score_next      = '0;
                    state_next      = S_ARM;
                end
            end
            S_ARM: begin
                pattern_next     = pick;
                round_timer_next = round_len(level);
                hit_mask_next    = '0;
                lockout_next     = '0;
                state_next       = S_SHOW;
            end
            S_SHOW: begin
                if (tick && (round_timer != '0)) begin
                    round_timer_next = round_timer - TIMER_W'(1);
                end
                hit_mask_next = hit_mask | (press & pattern_q);
                // Wrong presses outrank completion so a sloppy multi-press cannot score.
                if ((press & ~pattern_q) != '0) begin
                    lives_next   = lives_dec;
                    miss_next    = 1'b1;
                    lockout_next = lockout | (press & ~pattern_q);
                end else if (((hit_mask | press) & pattern_q) == pattern_q) begin
                    score_next = (&score) ? score : (score + SCORE_W'(1));
                    hit_next   = 1'b1;
                    state_next = S_RELEASE;
                end else if (round_timer == '0) begin
                    lives_next = lives_dec;
                    miss_next  = 1'b1;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (btn == '0) state_next = S_ARM;
            end
            default: state_next = S_IDLE;
        endcase

        level_next = level_of(score_next);

        if (in_game && ((game_timer_next == '0) || (lives_next == 3'd0))) begin
            state_next = S_OVER;
        end
    end

    assign mole_out  = (state == S_SHOW) ? pattern_q : '0;
    assign game_over = (state == S_OVER);

endmodule
